// File: rtl/coherent_mem_arbiter.sv
// N-core memory arbiter: per-class round-robin, snoop before data reads,
// dirty-line forwarding with RAM writeback, and per-core LL/SC reservations.
module coherent_mem_arbiter #(
  parameter int unsigned CPUS = 4,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [CPUS-1:0]     iREN,
  input  logic [CPUS*AW-1:0]  iaddr,
  output logic [CPUS-1:0]     iwait,
  output logic [CPUS*DW-1:0]  iload,
  input  logic [CPUS-1:0]     dREN,
  input  logic [CPUS-1:0]     dWEN,
  input  logic [CPUS*AW-1:0]  daddr,
  input  logic [CPUS*DW-1:0]  dstore,
  output logic [CPUS-1:0]     dwait,
  output logic [CPUS*DW-1:0]  dload,
  input  logic [CPUS-1:0]     cctrans,
  input  logic [CPUS-1:0]     ccwrite,
  output logic [CPUS-1:0]     ccwait,
  output logic [CPUS-1:0]     ccinv,
  output logic [AW-1:0]       ccsnoopaddr,
  input  logic [CPUS-1:0]     llsc_link,
  input  logic [CPUS-1:0]     llsc_clear,
  output logic [CPUS-1:0]     link_valid,
  input  logic [1:0]          ramstate,
  input  logic [DW-1:0]       ramload,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [AW-1:0]       ramaddr,
  output logic [DW-1:0]       ramstore,
  output logic                ram_err
);

  localparam int unsigned CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_DW, S_SNOOP, S_FWD, S_DR, S_IR} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   sel_q, sel_d, owner_q, owner_d;
  logic [CW-1:0]   rrd_q, rrd_d, rri_q, rri_d;
  logic [CPUS-1:0] link_valid_q, link_valid_d;
  logic [AW-1:0]   link_addr_q [CPUS];
  logic [AW-1:0]   link_addr_d [CPUS];
  logic            ram_err_q, ram_err_d;

  logic [AW-1:0]   iaddr_a  [CPUS];
  logic [AW-1:0]   daddr_a  [CPUS];
  logic [DW-1:0]   dstore_a [CPUS];
  logic [DW-1:0]   iload_a  [CPUS];
  logic [DW-1:0]   dload_a  [CPUS];

  logic [CPUS-1:0] snoop_hit;
  logic [CW-1:0]   snoop_low;
  logic            wr_done;
  logic [CW-1:0]   wr_core;
  logic [AW-1:0]   wr_addr;

  for (genvar g = 0; g < CPUS; g++) begin : g_lanes
    assign iaddr_a[g]          = iaddr[g*AW +: AW];
    assign daddr_a[g]          = daddr[g*AW +: AW];
    assign dstore_a[g]         = dstore[g*DW +: DW];
    assign iload[g*DW +: DW]   = iload_a[g];
    assign dload[g*DW +: DW]   = dload_a[g];
  end

  // First requester at or after ptr+1, wrapping; ptr itself is checked last.
  function automatic logic [CW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                            input logic [CW-1:0]   ptr);
    logic [CW-1:0] pick;
    int            idx;
    pick = '0;
    for (int k = int'(CPUS); k > 0; k--) begin
      idx = (int'(ptr) + k) % int'(CPUS);
      if (req[CW'(idx)]) pick = CW'(idx);
    end
    return pick;
  endfunction

  // Lowest-numbered snooped core reporting a Modified copy.
  always_comb begin
    snoop_hit = '0;
    snoop_low = '0;
    for (int c = 0; c < int'(CPUS); c++) snoop_hit[c] = ccwrite[c] && (CW'(c) != sel_q);
    for (int c = int'(CPUS) - 1; c >= 0; c--) if (snoop_hit[c]) snoop_low = CW'(c);
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    owner_d     = owner_q;
    rrd_d       = rrd_q;
    rri_d       = rri_q;
    iwait       = '1;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    wr_done     = 1'b0;
    wr_core     = '0;
    wr_addr     = '0;
    for (int c = 0; c < int'(CPUS); c++) begin
      iload_a[c] = '0;
      dload_a[c] = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (|dWEN) begin
          sel_d   = rr_pick(dWEN, rrd_q);
          state_d = S_DW;
        end else if (|dREN) begin
          sel_d   = rr_pick(dREN, rrd_q);
          state_d = S_SNOOP;
        end else if (|iREN) begin
          sel_d   = rr_pick(iREN, rri_q);
          state_d = S_IR;
        end
      end
      S_DW: begin
        if (!dWEN[sel_q]) begin
          state_d = S_IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = daddr_a[sel_q];
          ramstore = dstore_a[sel_q];
          if (ramstate == RAM_ACCESS) begin
            dwait[sel_q] = 1'b0;
            rrd_d        = sel_q;
            state_d      = S_IDLE;
            wr_done      = 1'b1;
            wr_core      = sel_q;
            wr_addr      = daddr_a[sel_q];
          end
        end
      end
      S_SNOOP: begin
        if (!dREN[sel_q]) begin
          state_d = S_IDLE;
        end else begin
          ccsnoopaddr = daddr_a[sel_q];
          for (int c = 0; c < int'(CPUS); c++) begin
            ccwait[c] = (CW'(c) != sel_q);
            ccinv[c]  = (CW'(c) != sel_q) && cctrans[sel_q];
          end
          if (|snoop_hit) begin
            owner_d = snoop_low;
            state_d = S_FWD;
          end else begin
            state_d = S_DR;
          end
        end
      end
      // Owner's line goes to the requester and is written back in the same access.
      S_FWD: begin
        if (!dREN[sel_q]) begin
          state_d = S_IDLE;
        end else begin
          ccwait[owner_q] = 1'b1;
          dload_a[sel_q]  = dstore_a[owner_q];
          ramWEN          = 1'b1;
          ramaddr         = daddr_a[sel_q];
          ramstore        = dstore_a[owner_q];
          if (ramstate == RAM_ACCESS) begin
            dwait[sel_q]   = 1'b0;
            dwait[owner_q] = 1'b0;
            rrd_d          = sel_q;
            state_d        = S_IDLE;
            wr_done        = 1'b1;
            wr_core        = owner_q;
            wr_addr        = daddr_a[sel_q];
          end
        end
      end
      S_DR: begin
        if (!dREN[sel_q]) begin
          state_d = S_IDLE;
        end else begin
          ramREN         = 1'b1;
          ramaddr        = daddr_a[sel_q];
          dload_a[sel_q] = ramload;
          if (ramstate == RAM_ACCESS) begin
            dwait[sel_q] = 1'b0;
            rrd_d        = sel_q;
            state_d      = S_IDLE;
          end
        end
      end
      S_IR: begin
        if (!iREN[sel_q]) begin
          state_d = S_IDLE;
        end else begin
          ramREN         = 1'b1;
          ramaddr        = iaddr_a[sel_q];
          iload_a[sel_q] = ramload;
          if (ramstate == RAM_ACCESS) begin
            iwait[sel_q] = 1'b0;
            rri_d        = sel_q;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reservations: remote write to the linked address breaks it; clear beats link.
  always_comb begin
    for (int c = 0; c < int'(CPUS); c++) begin
      link_valid_d[c] = link_valid_q[c];
      link_addr_d[c]  = link_addr_q[c];
      if (wr_done && (wr_core != CW'(c)) && (wr_addr == link_addr_q[c]))
        link_valid_d[c] = 1'b0;
      if (llsc_link[c]) begin
        link_valid_d[c] = 1'b1;
        link_addr_d[c]  = daddr_a[c];
      end
      if (llsc_clear[c]) link_valid_d[c] = 1'b0;
    end
    ram_err_d = ram_err_q | ((state_q != S_IDLE) && (ramstate == RAM_ERROR));
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      owner_q      <= '0;
      rrd_q        <= '0;
      rri_q        <= '0;
      link_valid_q <= '0;
      ram_err_q    <= 1'b0;
      for (int c = 0; c < int'(CPUS); c++) link_addr_q[c] <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      owner_q      <= owner_d;
      rrd_q        <= rrd_d;
      rri_q        <= rri_d;
      link_valid_q <= link_valid_d;
      ram_err_q    <= ram_err_d;
      for (int c = 0; c < int'(CPUS); c++) link_addr_q[c] <= link_addr_d[c];
    end
  end

  assign link_valid = link_valid_q;
  assign ram_err    = ram_err_q;

endmodule

// File: tb/tb_coherent_mem_arbiter.sv
// Scoreboard bench for coherent_mem_arbiter: per-request expectations are queued
// at issue time and matched by a monitor against every wait-low pulse.
module tb_coherent_mem_arbiter;

  localparam int unsigned CPUS = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;

  logic                CLK = 1'b0;
  logic                nRST;
  logic [CPUS-1:0]     iREN, dREN, dWEN, cctrans, ccwrite, llsc_link, llsc_clear;
  logic [CPUS*AW-1:0]  iaddr, daddr;
  logic [CPUS*DW-1:0]  dstore, iload, dload;
  logic [CPUS-1:0]     iwait, dwait, ccwait, ccinv, link_valid;
  logic [AW-1:0]       ccsnoopaddr, ramaddr;
  logic [1:0]          ramstate = 2'd0;
  logic [DW-1:0]       ramload = '0;
  logic [DW-1:0]       ramstore;
  logic                ramREN, ramWEN, ram_err;

  coherent_mem_arbiter #(.CPUS(CPUS), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .llsc_link(llsc_link), .llsc_clear(llsc_clear), .link_valid(link_valid),
    .ramstate(ramstate), .ramload(ramload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  // kind: 0 instr read, 1 data write, 2 data read, 3 forwarding-owner ack
  typedef struct { int core; int kind; logic [31:0] data; } exp_t;
  typedef struct { int cyc; int core; int kind; } log_t;

  exp_t expq[$];
  log_t lg[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          lat_min = 2, lat_max = 2, ram_cnt = 0, ram_lat = 0;
  bit          ram_hold = 0, ram_force_err = 0, ram_active = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single-port RAM with a random access latency, reacting after each edge.
  always @(posedge CLK) begin
    #2;
    if (!nRST) begin
      ramstate = 2'd0; ramload = '0; ram_active = 0;
    end else if (ram_force_err) begin
      ramstate = 2'd3;
    end else if (ramREN || ramWEN) begin
      if (!ram_active) begin
        ram_active = 1;
        ram_cnt    = 0;
        ram_lat    = int'($urandom_range(lat_max, lat_min));
      end
      ram_cnt++;
      if (!ram_hold && ram_cnt >= ram_lat) begin
        ramstate = 2'd2; ramload = ram_rd(ramaddr); ram_active = 0;
      end else begin
        ramstate = 2'd1; ramload = '0;
      end
    end else begin
      ram_active = 0; ramstate = 2'd0; ramload = '0;
    end
  end

  task automatic take(input int c, input bit is_d, input logic [31:0] val);
    int   idx;
    exp_t e;
    idx = -1;
    foreach (expq[i]) if (idx < 0 && expq[i].core == c) idx = i;
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_pulse core %0d dside=%0d: got a wait-low pulse, expected none", c, is_d);
      return;
    end
    e = expq[idx];
    expq.delete(idx);
    if ((e.kind == 0) == is_d) begin
      errors++;
      $display("FAIL pulse_kind core %0d: got dside=%0d expected kind %0d", c, is_d, e.kind);
    end else if ((e.kind == 0 || e.kind == 2) && val !== e.data) begin
      errors++;
      $display("FAIL load_data core %0d kind %0d: got %h expected %h", c, e.kind, val, e.data);
    end
    lg.push_back('{cyc, c, e.kind});
  endtask

  // Monitor: commit RAM writes and match every wait-low pulse to the scoreboard.
  always @(negedge CLK) begin
    cyc++;
    if (nRST && ramstate == 2'd2 && ramWEN) ram_mem[ramaddr] = ramstore;
    if (nRST) begin
      for (int c = 0; c < int'(CPUS); c++) begin
        if (!iwait[c]) take(c, 1'b0, iload[c*DW +: DW]);
        if (!dwait[c]) take(c, 1'b1, dload[c*DW +: DW]);
      end
    end
  end

  task automatic wait_pulse(input int c, input bit is_d, input string name);
    bit seen;
    seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge CLK);
      seen = is_d ? !dwait[c] : !iwait[c];
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout core %0d: got no wait-low pulse, expected one within 300 cycles", name, c);
    end
  endtask

  task automatic do_ifetch(input int c, input logic [31:0] a);
    @(posedge CLK); #1;
    iaddr[c*AW +: AW] = a;
    iREN[c] = 1'b1;
    expq.push_back('{c, 0, ref_rd(a)});
    wait_pulse(c, 1'b0, "ifetch");
    @(posedge CLK); #1;
    iREN[c] = 1'b0;
  endtask

  task automatic do_dwrite(input int c, input logic [31:0] a, input logic [31:0] v);
    @(posedge CLK); #1;
    daddr[c*AW +: AW]  = a;
    dstore[c*DW +: DW] = v;
    dWEN[c] = 1'b1;
    expq.push_back('{c, 1, 32'h0});
    ref_mem[a] = v;
    wait_pulse(c, 1'b1, "dwrite");
    @(posedge CLK); #1;
    dWEN[c] = 1'b0;
  endtask

  task automatic do_dread(input int c, input logic [31:0] a, input bit trans, input logic [31:0] expv);
    @(posedge CLK); #1;
    daddr[c*AW +: AW] = a;
    cctrans[c] = trans;
    dREN[c] = 1'b1;
    expq.push_back('{c, 2, expv});
    wait_pulse(c, 1'b1, "dread");
    @(posedge CLK); #1;
    dREN[c] = 1'b0;
    cctrans[c] = 1'b0;
  endtask

  task automatic pulse_link(input int c, input logic [31:0] a, input bit clr);
    @(posedge CLK); #1;
    daddr[c*AW +: AW] = a;
    llsc_link[c]  = 1'b1;
    llsc_clear[c] = clr;
    @(posedge CLK); #1;
    llsc_link[c]  = 1'b0;
    llsc_clear[c] = 1'b0;
  endtask

  task automatic rand_core(input int c);
    logic [31:0] a;
    int          op;
    repeat (16) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      op = int'($urandom_range(0, 2));
      a  = 32'(32'h1000 * (c + 1) + 4 * $urandom_range(0, 7));
      case (op)
        0:       do_ifetch(c, 32'h8000_0000 | a);
        1:       do_dwrite(c, a, $urandom);
        default: do_dread(c, a, 1'($urandom_range(0, 1)), ref_rd(a));
      endcase
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
    $fatal(1);
  end

  initial begin
    int          iord [5] = '{1, 2, 3, 0, 1};
    int          pord [3] = '{1*4+1, 3*4+2, 0*4+0};
    bit          seen;
    logic [31:0] v;

    nRST = 1'b0;
    iREN = '1; dREN = '1; dWEN = '1;
    iaddr = '0; daddr = '0; dstore = '0;
    cctrans = '0; ccwrite = '0; llsc_link = '0; llsc_clear = '0;

    // Reset held with every request asserted.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_iwait", 32'(iwait), 32'hF);
    chk("reset_dwait", 32'(dwait), 32'hF);
    chk("reset_ram_en", 32'({ramREN, ramWEN}), 32'h0);
    chk("reset_ccwait", 32'(ccwait), 32'h0);
    chk("reset_link_valid", 32'(link_valid), 32'h0);
    chk("reset_ram_err", 32'(ram_err), 32'h0);
    @(posedge CLK); #1;
    iREN = '0; dREN = '0; dWEN = '0;
    nRST = 1'b1;

    // Instruction round-robin starting after pointer 0.
    lg.delete();
    fork
      do_ifetch(0, 32'h100);
      begin do_ifetch(1, 32'h104); do_ifetch(1, 32'h104); end
      do_ifetch(2, 32'h108);
      do_ifetch(3, 32'h10C);
    join
    chk("iorder_count", 32'(lg.size()), 32'd5);
    for (int k = 0; k < 5 && k < lg.size(); k++) chk("iorder_core", 32'(lg[k].core), 32'(iord[k]));

    // Dirty-line forwarding from core 2 to core 0.
    ccwrite[2] = 1'b1;
    dstore[2*DW +: DW] = 32'hDEAD_BEEF;
    lg.delete();
    expq.push_back('{2, 3, 32'h0});
    fork
      do_dread(0, 32'h40, 1'b1, 32'hDEAD_BEEF);
      begin
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge CLK);
          seen = ccwait[1];
        end
        chk("snoop_seen", 32'(seen), 32'h1);
        chk("snoop_addr", ccsnoopaddr, 32'h40);
        chk("snoop_ccwait", 32'(ccwait), 32'hE);
        chk("snoop_ccinv", 32'(ccinv), 32'hE);
      end
    join
    ccwrite = '0;
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    chk("fwd_pulses", 32'(lg.size()), 32'd2);
    if (lg.size() == 2) chk("fwd_same_cycle", 32'(lg[1].cyc), 32'(lg[0].cyc));
    chk("fwd_writeback", ram_rd(32'h40), 32'hDEAD_BEEF);

    // Class priority: write, then read, then instruction.
    lg.delete();
    fork
      do_dwrite(1, 32'h1A0, 32'hA5A5_0001);
      do_dread(3, 32'h1A4, 1'b0, ref_rd(32'h1A4));
      do_ifetch(0, 32'h1A8);
    join
    chk("prio_count", 32'(lg.size()), 32'd3);
    for (int k = 0; k < 3 && k < lg.size(); k++)
      chk("prio_order", 32'(lg[k].core * 4 + lg[k].kind), 32'(pord[k]));

    // LL/SC reservation tracking for core 2.
    pulse_link(2, 32'h80, 1'b0);
    @(negedge CLK);
    chk("ll_set", 32'(link_valid[2]), 32'h1);
    do_dwrite(1, 32'h80, 32'h1111_0000);
    @(negedge CLK);
    chk("ll_remote_write", 32'(link_valid[2]), 32'h0);
    pulse_link(2, 32'h80, 1'b0);
    do_dwrite(2, 32'h80, 32'h2222_0000);
    @(negedge CLK);
    chk("ll_own_write", 32'(link_valid[2]), 32'h1);
    do_dwrite(1, 32'h84, 32'h3333_0000);
    @(negedge CLK);
    chk("ll_other_addr", 32'(link_valid[2]), 32'h1);
    pulse_link(2, 32'h80, 1'b1);
    @(negedge CLK);
    chk("ll_clear_wins", 32'(link_valid[2]), 32'h0);

    // Withdrawal while RAM is busy leaves the data pointer at core 0.
    do_dwrite(0, 32'h200, 32'h4444_0000);
    ram_hold = 1;
    @(posedge CLK); #1;
    daddr[3*AW +: AW]  = 32'h300;
    dstore[3*DW +: DW] = 32'h5555_0000;
    dWEN[3] = 1'b1;
    repeat (3) @(negedge CLK);
    chk("wd_busy_wen", 32'(ramWEN), 32'h1);
    chk("wd_busy_addr", ramaddr, 32'h300);
    @(posedge CLK); #1;
    dWEN[3] = 1'b0;
    @(negedge CLK);
    chk("wd_abort_wen", 32'(ramWEN), 32'h0);
    chk("wd_abort_dwait", 32'(dwait), 32'hF);
    @(negedge CLK);
    chk("wd_idle_ram", 32'({ramREN, ramWEN}), 32'h0);
    ram_hold = 0;
    lg.delete();
    fork
      do_dwrite(0, 32'h204, 32'h6666_0000);
      do_dwrite(3, 32'h304, 32'h7777_0000);
    join
    chk("wd_rr_count", 32'(lg.size()), 32'd2);
    if (lg.size() == 2) begin
      chk("wd_rr_first", 32'(lg[0].core), 32'd3);
      chk("wd_rr_second", 32'(lg[1].core), 32'd0);
    end
    chk("wd_write_data", ram_rd(32'h304), 32'h7777_0000);

    // Sticky RAM error.
    ram_force_err = 1;
    @(posedge CLK); #1;
    iaddr[0 +: AW] = 32'h500;
    iREN[0] = 1'b1;
    repeat (4) @(negedge CLK);
    chk("err_set", 32'(ram_err), 32'h1);
    chk("err_no_pulse", 32'(iwait), 32'hF);
    @(posedge CLK); #1;
    iREN[0] = 1'b0;
    ram_force_err = 0;
    repeat (3) @(negedge CLK);
    chk("err_sticky", 32'(ram_err), 32'h1);
    chk("err_back_idle", 32'({ramREN, ramWEN}), 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("err_reset", 32'(ram_err), 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Random concurrent traffic from all cores in disjoint address regions.
    lat_min = 1; lat_max = 3;
    fork
      rand_core(0);
      rand_core(1);
      rand_core(2);
      rand_core(3);
    join

    repeat (5) @(negedge CLK);
    chk("queue_drained", 32'(expq.size()), 32'h0);
    v = ram_rd(32'h80);
    chk("ram_final_80", v, 32'h2222_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
